issue_queue: RTL

Age-ordered, collapsing issue queue directly downstream of the dispatch queue. Accepts up to `WR_WIDTH` renamed micro-ops per cycle over a valid/ready handshake and holds them until both source operands are ready. Tracks operand readiness from writeback broadcasts and issues the oldest ready entry, one per cycle, to a single functional-unit port.

---
 rtl/issue_queue.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// issue_queue: age-ordered, collapsing issue queue.
// Slot 0 is the oldest entry. Occupied slots are always 0..count-1.
// Each cycle the queue issues at most one entry: the oldest whose sources are both ready.
// Optional feature: define IQ_WB_BYPASS_EN to let an entry issue in the same cycle as the
// writeback broadcast that wakes it.
module issue_queue #(
    parameter int unsigned IQ_DEPTH  = 8,
    parameter int unsigned WR_WIDTH  = 2,
    parameter int unsigned WB_WIDTH  = 4,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned PAYLOAD_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [WR_WIDTH-1:0]           enq_valid_i,
    input  logic [WR_WIDTH*PREG_W-1:0]    enq_src0_i,
    input  logic [WR_WIDTH*PREG_W-1:0]    enq_src1_i,
    input  logic [WR_WIDTH-1:0]           enq_src0_rdy_i,
    input  logic [WR_WIDTH-1:0]           enq_src1_rdy_i,
    input  logic [WR_WIDTH*PREG_W-1:0]    enq_pdest_i,
    input  logic [WR_WIDTH*PAYLOAD_W-1:0] enq_payload_i,
    output logic                          enq_ready_o,
    input  logic [WB_WIDTH-1:0]           wb_valid_i,
    input  logic [WB_WIDTH*PREG_W-1:0]    wb_pdest_i,
    output logic                          issue_valid_o,
    input  logic                          issue_ready_i,
    output logic [PREG_W-1:0]             issue_pdest_o,
    output logic [PREG_W-1:0]             issue_src0_o,
    output logic [PREG_W-1:0]             issue_src1_o,
    output logic [PAYLOAD_W-1:0]          issue_payload_o,
    output logic [$clog2(IQ_DEPTH+1)-1:0] count_o
);

    localparam int unsigned CNT_W     = $clog2(IQ_DEPTH + 1);
    localparam int unsigned IDX_W     = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned ENQ_LIMIT = IQ_DEPTH - WR_WIDTH;

    typedef struct packed {
        logic [PREG_W-1:0]    src0;
        logic [PREG_W-1:0]    src1;
        logic [PREG_W-1:0]    pdest;
        logic                 src0_rdy;
        logic                 src1_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t              slot_q  [IQ_DEPTH];
    entry_t              slot_n  [IQ_DEPTH];
    entry_t              woken   [IQ_DEPTH];
    entry_t              shifted [IQ_DEPTH];
    entry_t              lane_e  [WR_WIDTH];
    entry_t              sel_e;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_n;
    logic [CNT_W-1:0]    base_cnt;
    logic [CNT_W-1:0]    wr_ptr;
    logic [IQ_DEPTH-1:0] cand;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_found;
    logic                fire;

    // True when any valid broadcast names this physical register.
    function automatic logic wb_hit(input logic [PREG_W-1:0]          preg,
                                    input logic [WB_WIDTH-1:0]        v,
                                    input logic [WB_WIDTH*PREG_W-1:0] p);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < int'(WB_WIDTH); k++) begin
            if (v[k] && (p[k*PREG_W +: PREG_W] == preg)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Apply this cycle's broadcasts to stored entries and mark the issue candidates.
    always_comb begin
        cand = '0;
        for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            woken[i]          = slot_q[i];
            woken[i].src0_rdy = slot_q[i].src0_rdy | wb_hit(slot_q[i].src0, wb_valid_i, wb_pdest_i);
            woken[i].src1_rdy = slot_q[i].src1_rdy | wb_hit(slot_q[i].src1, wb_valid_i, wb_pdest_i);
`ifdef IQ_WB_BYPASS_EN
            cand[i] = (i < int'(count_q)) && woken[i].src0_rdy && woken[i].src1_rdy;
`else
            cand[i] = (i < int'(count_q)) && slot_q[i].src0_rdy && slot_q[i].src1_rdy;
`endif
        end
    end

    // Oldest-first select: scanning downward lets the lowest candidate win.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = int'(IQ_DEPTH) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Issue fields come from the registered slot and read as zero when nothing is selected.
    always_comb begin
        sel_e = slot_q[sel_idx];
        if (!sel_found) sel_e = '0;
    end

    assign issue_valid_o   = sel_found;
    assign issue_pdest_o   = sel_e.pdest;
    assign issue_src0_o    = sel_e.src0;
    assign issue_src1_o    = sel_e.src1;
    assign issue_payload_o = sel_e.payload;
    assign enq_ready_o     = (count_q <= CNT_W'(ENQ_LIMIT));
    assign count_o         = count_q;
    assign fire            = sel_found & issue_ready_i;

    // Next state: collapse the issued slot, then append the accepted lanes behind the survivors.
    always_comb begin
        base_cnt = count_q - CNT_W'(fire);
        for (int i = 0; i < int'(IQ_DEPTH) - 1; i++) begin
            shifted[i] = woken[i+1];
        end
        shifted[IQ_DEPTH-1] = '0;
        for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            slot_n[i] = (fire && (i >= int'(sel_idx))) ? shifted[i] : woken[i];
        end
        wr_ptr = base_cnt;
        for (int j = 0; j < int'(WR_WIDTH); j++) begin
            lane_e[j].src0     = enq_src0_i[j*PREG_W +: PREG_W];
            lane_e[j].src1     = enq_src1_i[j*PREG_W +: PREG_W];
            lane_e[j].pdest    = enq_pdest_i[j*PREG_W +: PREG_W];
            lane_e[j].payload  = enq_payload_i[j*PAYLOAD_W +: PAYLOAD_W];
            lane_e[j].src0_rdy = enq_src0_rdy_i[j] |
                                 wb_hit(enq_src0_i[j*PREG_W +: PREG_W], wb_valid_i, wb_pdest_i);
            lane_e[j].src1_rdy = enq_src1_rdy_i[j] |
                                 wb_hit(enq_src1_i[j*PREG_W +: PREG_W], wb_valid_i, wb_pdest_i);
            if (enq_valid_i[j] && enq_ready_o) begin
                for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                    if (i == int'(wr_ptr)) slot_n[i] = lane_e[j];
                end
                wr_ptr = wr_ptr + CNT_W'(1);
            end
        end
        count_n = wr_ptr;
        if (flush_i) begin
            for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                slot_n[i] = '0;
            end
            count_n = '0;
        end
    end

    // Slot storage and occupancy count, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_n;
            for (int i = 0; i < int'(IQ_DEPTH); i++) begin
                slot_q[i] <= slot_n[i];
            end
        end
    end

endmodule
